fpmult_arbiter: RTL

Round-robin scheduler that shares one pipelined floating-point multiplier (sign, 7-bit excess-64 exponent, 24-bit hex-normalized mantissa) among NREQ requesters. Each requester gets a valid/ready request port and a response strobe. The block issues at most one operand pair per cycle into the multiplier. It tracks in-flight operations with a tag pipeline matched to the multiplier latency and routes each result back to the requester that issued it. It sits between the compute clients and the single multiplier instance.

---
 rtl/fpmult_arbiter_if.sv | 22 ++
 rtl/fpmult_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/fpmult_arbiter_if.sv
// Requester-side bundle of the shared multiplier arbiter: request handshake,
// packed operands (requester i at bits [32i+31:32i]) and the response strobe.
interface fpmult_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [31:0]        rsp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/fpmult_arbiter.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters;
// a tag pipeline matched to LATENCY routes each result back to its issuer.
module fpmult_arbiter #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 2
) (
   input  logic            clock,
   input  logic            reset,
   fpmult_arbiter_if.slave bus,
   output logic [31:0]     mult_dataa,
   output logic [31:0]     mult_datab,
   input  logic [31:0]     mult_result,
   output logic [3:0]      inflight,
   output logic            idle
);

   logic [2:0] ptr;
   logic       grant_any;
   logic [2:0] grant_id;
   logic       rsp_any;
   logic       tag_v  [LATENCY];
   logic [2:0] tag_id [LATENCY];

   // Search starts at ptr and wraps; no grant is ever made while reset is high.
   always_comb begin
      int idx;
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      grant_any = 1'b0;
      grant_id  = 3'd0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(ptr) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_any && !reset && bus.req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = 3'(idx);
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      mult_dataa    = 32'h0;
      mult_datab    = 32'h0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_any && grant_id == 3'(i)) begin
            bus.req_ready[i] = 1'b1;
            mult_dataa       = bus.req_a[32*i +: 32];
            mult_datab       = bus.req_b[32*i +: 32];
         end
      end
   end

   assign rsp_any = tag_v[LATENCY-1] && !reset;

   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_data  = rsp_any ? mult_result : 32'h0;
      for (int i = 0; i < NREQ; i++) begin
         if (rsp_any && tag_id[LATENCY-1] == 3'(i)) bus.rsp_valid[i] = 1'b1;
      end
   end

   assign idle = (reset || inflight == 4'd0) && (bus.req_valid == '0);

   // NOTE: all state below uses non-blocking assignments so every stage reads
   // the value from before the clock edge, which is what makes it a shift register.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr      <= 3'd0;
         inflight <= 4'd0;
         // NOTE: the tag pipeline is a handful of flops, not a RAM, and its valid
         // bits must clear so results emerging after reset are discarded.
         for (int s = 0; s < LATENCY; s++) begin
            tag_v[s]  <= 1'b0;
            tag_id[s] <= 3'd0;
         end
      end else begin
         if (grant_any) ptr <= (int'(grant_id) == NREQ - 1) ? 3'd0 : grant_id + 3'd1;

         tag_v[0]  <= grant_any;
         tag_id[0] <= grant_id;
         for (int s = 1; s < LATENCY; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end

         case ({grant_any, rsp_any})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule
